simul_axi_read_tracker: RTL



---
 rtl/simul_axi_read_tracker.sv | 202 ++++++++++++++++++++
 1 files changed

// File: rtl/simul_axi_read_tracker.sv
// AXI read-channel tracker for simulation: queues AR commands, predicts the word
// address of every R beat and flags underrun/overrun, RLAST, RID and burst-type errors.
module simul_axi_read_tracker #(
  parameter int ADDRESS_WIDTH = 10,
  parameter int ID_WIDTH      = 12,
  parameter int LEN_WIDTH     = 4,
  parameter int DEPTH_LOG2    = 3,
  parameter int CHECK_ID      = 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     rcmd,
  input  logic [ADDRESS_WIDTH-1:0] raddr,
  input  logic [LEN_WIDTH-1:0]     rlen,
  input  logic [1:0]               rburst,
  input  logic [ID_WIDTH-1:0]      rid_cmd,
  input  logic                     data_stb,
  input  logic                     last,
  input  logic [ID_WIDTH-1:0]      rid,
  output logic [ADDRESS_WIDTH-1:0] addr_out,
  output logic                     burst,
  output logic [DEPTH_LOG2:0]      pending,
  output logic                     full,
  output logic                     err_out,
  output logic [5:0]               err_code,
  input  logic                     err_clr
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int PW    = DEPTH_LOG2 + 1;

  typedef enum logic {IDLE, BURST} state_t;

  state_t                    state_q, state_d;
  logic [PW-1:0]             wr_q, wr_d, rd_q, rd_d;
  logic [ID_WIDTH-1:0]       act_id_q, act_id_d;
  logic [ADDRESS_WIDTH-1:0]  act_start_q, act_start_d;
  logic [LEN_WIDTH-1:0]      act_len_q, act_len_d;
  logic [1:0]                act_type_q, act_type_d;
  logic [LEN_WIDTH-1:0]      beat_q, beat_d;
  logic [5:0]                err_code_q, err_code_d;
  logic                      err_out_q, err_out_d;

  logic [ID_WIDTH-1:0]       id_mem   [DEPTH];
  logic [ADDRESS_WIDTH-1:0]  addr_mem [DEPTH];
  logic [LEN_WIDTH-1:0]      len_mem  [DEPTH];
  logic [1:0]                type_mem [DEPTH];

  logic [PW-1:0]             count;
  logic                      empty, full_w, push;
  logic [DEPTH_LOG2-1:0]     head;
  logic [ID_WIDTH-1:0]       head_id;
  logic [ADDRESS_WIDTH-1:0]  head_addr;
  logic [LEN_WIDTH-1:0]      head_len;
  logic [1:0]                head_type;
  logic                      head_bad;
  logic [5:0]                errs;

  function automatic logic [ADDRESS_WIDTH-1:0] beat_addr(
    input logic [ADDRESS_WIDTH-1:0] s,
    input logic [LEN_WIDTH-1:0]     len,
    input logic [LEN_WIDTH-1:0]     b,
    input logic [1:0]               t
  );
    logic [ADDRESS_WIDTH-1:0] mask, inc;
    mask = ADDRESS_WIDTH'(len);
    inc  = s + ADDRESS_WIDTH'(b);
    case (t)
      2'd0:    beat_addr = s;
      2'd2:    beat_addr = (s & ~mask) | (inc & mask);
      default: beat_addr = inc;
    endcase
  endfunction

  function automatic logic bad_burst(input logic [1:0] t, input logic [LEN_WIDTH-1:0] len);
    logic legal_wrap;
    legal_wrap = (len == LEN_WIDTH'(1)) || (len == LEN_WIDTH'(3)) ||
                 (len == LEN_WIDTH'(7)) || (len == LEN_WIDTH'(15));
    bad_burst = (t == 2'd3) || ((t == 2'd2) && !legal_wrap);
  endfunction

  assign count     = wr_q - rd_q;
  assign empty     = (count == '0);
  assign full_w    = (count == PW'(DEPTH));
  assign push      = rcmd && !full_w;
  assign head      = rd_q[DEPTH_LOG2-1:0];
  assign head_id   = id_mem[head];
  assign head_addr = addr_mem[head];
  assign head_len  = len_mem[head];
  assign head_type = type_mem[head];
  assign head_bad  = bad_burst(head_type, head_len);

  always_comb begin
    state_d     = state_q;
    wr_d        = wr_q;
    rd_d        = rd_q;
    act_id_d    = act_id_q;
    act_start_d = act_start_q;
    act_len_d   = act_len_q;
    act_type_d  = act_type_q;
    beat_d      = beat_q;
    errs        = '0;

    // Overrun is judged on the registered fill level, before any same-cycle pop.
    if (rcmd && full_w) errs[1] = 1'b1;
    if (push) wr_d = wr_q + PW'(1);

    if (data_stb) begin
      case (state_q)
        IDLE: begin
          if (empty) begin
            errs[0] = 1'b1;
          end else begin
            rd_d = rd_q + PW'(1);
            if (head_bad) errs[5] = 1'b1;
            if ((CHECK_ID != 0) && (rid != head_id)) errs[4] = 1'b1;
            if (head_len == '0) begin
              if (!last) errs[3] = 1'b1;
            end else if (last) begin
              errs[2] = 1'b1;
            end else begin
              state_d     = BURST;
              act_id_d    = head_id;
              act_start_d = head_addr;
              act_len_d   = head_len;
              act_type_d  = head_bad ? 2'd1 : head_type;
              beat_d      = LEN_WIDTH'(1);
            end
          end
        end
        BURST: begin
          if ((CHECK_ID != 0) && (rid != act_id_q)) errs[4] = 1'b1;
          if (beat_q == act_len_q) begin
            state_d = IDLE;
            if (!last) errs[3] = 1'b1;
          end else if (last) begin
            errs[2] = 1'b1;
            state_d = IDLE;
          end else begin
            beat_d = beat_q + LEN_WIDTH'(1);
          end
        end
        default: state_d = IDLE;
      endcase
    end

    err_code_d = (err_clr ? 6'd0 : err_code_q) | errs;
    err_out_d  = |errs;
  end

  always_comb begin
    if (state_q == BURST)
      addr_out = beat_addr(act_start_q, act_len_q, beat_q, act_type_q);
    else if (!empty)
      addr_out = head_addr;
    else
      addr_out = '0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      wr_q        <= '0;
      rd_q        <= '0;
      act_id_q    <= '0;
      act_start_q <= '0;
      act_len_q   <= '0;
      act_type_q  <= '0;
      beat_q      <= '0;
      err_code_q  <= '0;
      err_out_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      wr_q        <= wr_d;
      rd_q        <= rd_d;
      act_id_q    <= act_id_d;
      act_start_q <= act_start_d;
      act_len_q   <= act_len_d;
      act_type_q  <= act_type_d;
      beat_q      <= beat_d;
      err_code_q  <= err_code_d;
      err_out_q   <= err_out_d;
    end
  end

  // Queue storage carries no reset; the pointers alone decide what is valid.
  always_ff @(posedge clk) begin
    if (push) begin
      id_mem[wr_q[DEPTH_LOG2-1:0]]   <= rid_cmd;
      addr_mem[wr_q[DEPTH_LOG2-1:0]] <= raddr;
      len_mem[wr_q[DEPTH_LOG2-1:0]]  <= rlen;
      type_mem[wr_q[DEPTH_LOG2-1:0]] <= rburst;
    end
  end

  assign burst    = (state_q == BURST);
  assign pending  = count;
  assign full     = full_w;
  assign err_out  = err_out_q;
  assign err_code = err_code_q;

endmodule
